// File: rtl/inv_mix_col_iter.sv
// Iterative AES InvMixColumns engine.
// A 128-bit state is accepted over a valid/ready handshake and transformed
// NCOL columns per cycle through a shared datapath. The result is then held
// on out_state until the consumer takes it.
// Column c sits at bits [127-32c -: 32], and byte 0 of a column is its MSB byte.
// Legal NCOL values are 1, 2 and 4, so 4/NCOL is a whole number of cycles.
module inv_mix_col_iter #(
    parameter int NCOL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Counter increment. It is one bit wider than the counter so that
    // "reached 4" shows up as the carry.
    localparam logic [2:0] STEP = 3'(NCOL);

    fsm_t         fsm_r;
    fsm_t         fsm_s;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_s;
    logic [2:0]   cnt_sum_s;
    logic [127:0] state_r;
    logic [127:0] state_s;
    logic [127:0] mixed_s;
    logic         in_ready_r;
    logic         out_valid_r;

    // GF(2^8) multiply by x, modulo 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column, built from xtime chains (x2, x4, x8)
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] x  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] t2;
        logic [7:0] t4;
        logic [7:0] t8;
        for (int i = 0; i < 4; i++) begin
            x[i]  = col[31 - 8*i -: 8];
            t2    = xtime(x[i]);
            t4    = xtime(t2);
            t8    = xtime(t4);
            m9[i] = t8 ^ x[i];
            mb[i] = t8 ^ t2 ^ x[i];
            md[i] = t8 ^ t4 ^ x[i];
            me[i] = t8 ^ t4 ^ t2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Transform the NCOL columns addressed by the counter; other columns pass through
    always_comb begin
        logic [1:0] col_idx;
        int         base;
        mixed_s = state_r;
        col_idx = 2'd0;
        base    = 0;
        for (int k = 0; k < NCOL; k++) begin
            col_idx = cnt_r + 2'(k);
            base    = 96 - 32 * int'(col_idx);
            mixed_s[base +: 32] = inv_mix_column(state_r[base +: 32]);
        end
    end

    // Next-state logic. abort overrides every transition, including a same-cycle accept.
    always_comb begin
        fsm_s     = fsm_r;
        cnt_s     = cnt_r;
        state_s   = state_r;
        cnt_sum_s = {1'b0, cnt_r} + STEP;
        if (abort) begin
            fsm_s = IDLE;
            cnt_s = 2'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_s = in_state;
                        cnt_s   = 2'd0;
                        fsm_s   = BUSY;
                    end else begin
                        fsm_s = IDLE;
                    end
                end
                BUSY: begin
                    state_s = mixed_s;
                    cnt_s   = cnt_sum_s[1:0];
                    if (cnt_sum_s[2]) begin
                        fsm_s = DONE;
                    end else begin
                        fsm_s = BUSY;
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) begin
                        fsm_s = IDLE;
                    end else begin
                        fsm_s = DONE;
                    end
                end
                default: begin
                    fsm_s = IDLE;
                    cnt_s = 2'd0;
                end
            endcase
        end
    end

    // State, counter and data registers. The handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            cnt_r       <= 2'd0;
            state_r     <= 128'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            fsm_r       <= fsm_s;
            cnt_r       <= cnt_s;
            state_r     <= state_s;
            in_ready_r  <= (fsm_s == IDLE);
            out_valid_r <= (fsm_s == DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_state = state_r;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Self-checking bench for inv_mix_col_iter.
// It runs three instances, one each for NCOL = 1, 2 and 4. Expected values
// come from a GF(2^8) matrix model that uses polynomial multiplication with
// 0x11b reduction.
module tb_inv_mix_col_iter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        abort_v;
    logic [2:0]        in_valid_v;
    logic [2:0]        in_ready_v;
    logic [2:0][127:0] in_state_v;
    logic [2:0]        out_valid_v;
    logic [2:0]        out_ready_v;
    logic [2:0][127:0] out_state_v;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] AB_IN  = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc;
    localparam logic [127:0] AB_OUT = 128'hdb135345_db135345_db135345_db135345;
    localparam logic [127:0] ALL_C6 = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

    always #5 clk = ~clk;

    inv_mix_col_iter #(.NCOL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .abort(abort_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_state(in_state_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_state(out_state_v[0]));
    inv_mix_col_iter #(.NCOL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .abort(abort_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_state(in_state_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_state(out_state_v[1]));
    inv_mix_col_iter #(.NCOL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .abort(abort_v[2]),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_state(in_state_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_state(out_state_v[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial product followed by reduction modulo 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant column mix: y_r = sum_j coef[(j-r) mod 4] * x_j
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coefs);
        logic [7:0]   coef [4];
        logic [7:0]   x    [4];
        logic [7:0]   y;
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 4; i++) coef[i] = coefs[31 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) x[i] = s[127 - 32*c - 8*i -: 8];
            for (int row = 0; row < 4; row++) begin
                y = 8'd0;
                for (int j = 0; j < 4; j++) y = y ^ gmul(coef[(j - row + 4) % 4], x[j]);
                r[127 - 32*c - 8*row -: 8] = y;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return mix(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return mix(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full transaction: accept, latency, busy-phase flags, result,
    // optional backpressure hold, then transfer.
    task automatic txn(input int d, input logic [127:0] din, input logic [127:0] dexp, input int hold);
        int w;
        int lat;
        bit busy_ok;
        in_state_v[d] = din;
        in_valid_v[d] = 1'b1;
        w = 0;
        while (!in_ready_v[d] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk($sformatf("d%0d_ready_wait", d), 128'(in_ready_v[d]), 128'd1);
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            if (in_ready_v[d]) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end while (!out_valid_v[d] && lat < 20);
        chk($sformatf("d%0d_latency", d), 128'(lat), 128'(4 >> d));
        chk($sformatf("d%0d_busy_ready_low", d), 128'(busy_ok), 128'd1);
        chk($sformatf("d%0d_out_valid", d), 128'(out_valid_v[d]), 128'd1);
        chk($sformatf("d%0d_out_state", d), out_state_v[d], dexp);
        for (int i = 0; i < hold; i++) begin
            in_valid_v[d] = 1'(i % 2);
            in_state_v[d] = rnd128();
            @(posedge clk); #1;
            chk($sformatf("d%0d_hold_valid", d), 128'(out_valid_v[d]), 128'd1);
            chk($sformatf("d%0d_hold_state", d), out_state_v[d], dexp);
            chk($sformatf("d%0d_hold_ready", d), 128'(in_ready_v[d]), 128'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0;
        chk($sformatf("d%0d_post_valid", d), 128'(out_valid_v[d]), 128'd0);
        chk($sformatf("d%0d_post_ready", d), 128'(in_ready_v[d]), 128'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            chk($sformatf("d%0d_no_stray_accept", d), 128'(in_ready_v[d]), 128'd1);
        end
    endtask

    // Bounded watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int nval;
        int per;
        bit quiet;
        logic [127:0] orig;
        logic [127:0] v;

        rst_n       = 1'b0;
        abort_v     = 3'b000;
        in_valid_v  = 3'b000;
        out_ready_v = 3'b000;
        in_state_v  = '0;

        // Model self-consistency on the known vector
        chk("model_kv", inv_mix(KV_IN), KV_OUT);

        // Reset state
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_ready", d), 128'(in_ready_v[d]), 128'd0);
            chk($sformatf("d%0d_rst_valid", d), 128'(out_valid_v[d]), 128'd0);
            chk($sformatf("d%0d_rst_state", d), out_state_v[d], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("d%0d_ready_after_rst", d), 128'(in_ready_v[d]), 128'd1);

        // Known vector and fixed points
        txn(0, KV_IN, KV_OUT, 0);
        for (int d = 0; d < 3; d++) begin
            txn(d, ALL_C6, ALL_C6, 0);
            txn(d, 128'd0, 128'd0, 0);
        end

        // Random round trip through the forward model
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200; i++) begin
                orig = rnd128();
                txn(d, fwd_mix(orig), orig, int'($urandom_range(0, 2)));
            end
        end

        // Backpressure for 10 cycles
        for (int d = 0; d < 3; d++) begin
            v = rnd128();
            txn(d, v, inv_mix(v), 10);
        end

        // Back-to-back stream
        for (int d = 0; d < 3; d++) begin
            per = (4 >> d) + 2;
            v = rnd128();
            in_state_v[d]  = v;
            in_valid_v[d]  = 1'b1;
            out_ready_v[d] = 1'b1;
            prev = -1;
            nval = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (out_valid_v[d]) begin
                    chk($sformatf("d%0d_stream_state", d), out_state_v[d], inv_mix(v));
                    if (prev >= 0)
                        chk($sformatf("d%0d_stream_period", d), 128'(c - prev), 128'(per));
                    prev = c;
                    nval++;
                end
            end
            in_valid_v[d] = 1'b0;
            chk($sformatf("d%0d_stream_count", d), 128'(nval >= 40 / per - 1), 128'd1);
            repeat (8) @(posedge clk);
            #1;
            out_ready_v[d] = 1'b0;
            chk($sformatf("d%0d_stream_drain_ready", d), 128'(in_ready_v[d]), 128'd1);
        end

        // Abort in the 2nd BUSY cycle, then abort colliding with an accept
        for (int d = 0; d < 2; d++) begin
            in_state_v[d] = KV_IN;
            in_valid_v[d] = 1'b1;
            @(posedge clk); #1;
            in_valid_v[d] = 1'b0;
            @(posedge clk); #1;
            abort_v[d] = 1'b1;
            @(posedge clk); #1;
            abort_v[d] = 1'b0;
            chk($sformatf("d%0d_abort_ready", d), 128'(in_ready_v[d]), 128'd1);
            chk($sformatf("d%0d_abort_valid", d), 128'(out_valid_v[d]), 128'd0);
            quiet = 1'b1;
            out_ready_v[d] = 1'b1;
            repeat (6) begin
                @(posedge clk); #1;
                if (out_valid_v[d] || !in_ready_v[d]) quiet = 1'b0;
            end
            out_ready_v[d] = 1'b0;
            chk($sformatf("d%0d_abort_quiet", d), 128'(quiet), 128'd1);
            in_state_v[d] = KV_IN;
            in_valid_v[d] = 1'b1;
            abort_v[d]    = 1'b1;
            @(posedge clk); #1;
            in_valid_v[d] = 1'b0;
            abort_v[d]    = 1'b0;
            chk($sformatf("d%0d_abort_drops_accept", d), 128'(in_ready_v[d]), 128'd1);
            txn(d, AB_IN, AB_OUT, 0);
        end

        // Asynchronous reset mid-BUSY, off a clock edge
        in_state_v[0] = KV_IN;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid_v[0]), 128'd0);
        chk("arst_ready", 128'(in_ready_v[0]), 128'd0);
        chk("arst_state", out_state_v[0], 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready_release", 128'(in_ready_v[0]), 128'd1);
        quiet = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid_v[0]) quiet = 1'b0;
        end
        chk("arst_no_output", 128'(quiet), 128'd1);
        txn(0, KV_IN, KV_OUT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_col_iter.md
Name: inv_mix_col_iter

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath.
- Accepts a full 128-bit state over a valid/ready handshake.
- Transforms the state column by column through a shared InvMixColumns datapath.
- Returns the result over a valid/ready handshake.
- Inverse counterpart of the forward 32-bit MixColumns used in encryption; sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.

Parameters:
- NCOL, default 1: columns transformed per cycle; legal values 1, 2, 4. Processing latency is 4/NCOL cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- abort  input  1  synchronous flush; returns the block to IDLE
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  128  column c is in_state[127-32c -: 32]; byte 0 of each column is its MSB byte
- out_valid  output  1  out_state is valid
- out_ready  input  1  consumer accepts out_state
- out_state  output  128  transformed state; same byte ordering as in_state

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, column counter=0, state register=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first clock after release.
  - out_valid=0, out_state=0.
- Per-column math, with input bytes x0..x3 and outputs y0..y3:
  - y0 = 0e·x0 ^ 0b·x1 ^ 0d·x2 ^ 09·x3
  - y1 = 09·x0 ^ 0e·x1 ^ 0b·x2 ^ 0d·x3
  - y2 = 0d·x0 ^ 09·x1 ^ 0e·x2 ^ 0b·x3
  - y3 = 0b·x0 ^ 0d·x1 ^ 09·x2 ^ 0e·x3
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b), built from xtime chains.
  - All intermediates are 8-bit; no wider carries.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: load in_state into the state register, counter=0, go to BUSY.
  - BUSY:
    - in_ready=0, out_valid=0.
    - Each cycle, replace columns [counter .. counter+NCOL-1] in place with their transform, then counter += NCOL.
    - When counter reaches 4, go to DONE. Counter is 2 bits wide and wraps to 0 at this point.
  - DONE:
    - out_valid=1; out_state = state register, held stable.
    - in_valid is ignored.
    - On out_valid&out_ready: go to IDLE.
- Latency: with accept at edge N, out_valid is high from edge N+4/NCOL.
  - Minimum cycles between successive accepts: 4/NCOL+2 (one DONE cycle with out_ready=1, one IDLE cycle).
- out_state changes only while in BUSY or on load. It never changes while out_valid=1.
- Backpressure: out_ready=0 holds DONE indefinitely; data is not lost.
- abort:
  - Synchronous, and has priority over every transition.
  - Next state is IDLE, counter=0, out_valid=0.
  - State register contents are don't-care, but must not be presented (out_valid=0).
  - abort in the same cycle as an in_valid&in_ready accept: the accept is dropped.
- Reset mid-operation: same effect as abort, but immediate (asynchronous); no output is produced.
- out_state is undefined when out_valid=0; benches must not check it.

Test Plan:
- Single column, NCOL=1: in_state = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_state = db135345_f20a225c_01010101_d4d4d4d5.
  - out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- Round-trip: 200 random 128-bit states, first passed through the forward mix-column reference model, then applied -> output equals the original state, for NCOL=1, 2 and 4.
  - Latency measured as 4, 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1 and out_state stays constant.
  - in_valid pulses during this window are not accepted.
  - When out_ready is raised: one transfer occurs, then in_ready=1 on the next cycle.
- Identity/fixed points: in_state = all c6 -> all c6; all 00 -> all 00.
  - Back-to-back stream with in_valid and out_ready held high achieves one result per 4/NCOL+2 cycles.
- abort: assert abort on the 2nd BUSY cycle -> next cycle is IDLE, out_valid never rises, in_ready=1.
  - A following state 8e4da1bc repeated ×4 produces db135345 repeated ×4.
- Asynchronous reset: drop rst_n mid-BUSY and off a clock edge -> out_valid=0 and in_ready=0 immediately.
  - After release, the first transaction completes correctly.
